// File: rtl/mips_defs.sv
// Shared MIPS decode constants for the hazard/stall logic.
// No logic, no latency.
// No flow control; constants and one pure helper function only.
package mips_defs;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  // Tuse: cycles until the operand is needed; TUSE_NONE never compares below any Tnew
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles until the result can be forwarded, as seen from E
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam logic [4:0] REG_RA = 5'd31;

  // One stage further down the pipe a result is one cycle closer
  function automatic logic [1:0] tnew_advance(input logic [1:0] t);
    return (t == TNEW_0) ? TNEW_0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Decodes one instruction into destination register, Tnew and Tuse for rs/rt.
// Purely combinational, zero latency.
// No flow control; outputs follow i_ir in the same cycle.
module instr_decode
  import mips_defs::*;
(
  input  logic [31:0] i_ir,
  output logic [4:0]  o_dest,
  output logic [1:0]  o_tnew,
  output logic [1:0]  o_tuse_rs,
  output logic [1:0]  o_tuse_rt,
  output logic        o_is_md_start,
  output logic        o_is_md_access
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic [4:0] w_unused_shamt;

  assign w_op           = i_ir[31:26];
  assign w_fn           = i_ir[5:0];
  assign w_rt           = i_ir[20:16];
  assign w_rd           = i_ir[15:11];
  assign w_unused_shamt = i_ir[10:6];

  // Table decode; anything unrecognised writes nothing and reads nothing
  always_comb begin
    o_dest         = 5'd0;
    o_tnew         = TNEW_0;
    o_tuse_rs      = TUSE_NONE;
    o_tuse_rt      = TUSE_NONE;
    o_is_md_start  = 1'b0;
    o_is_md_access = 1'b0;
    unique case (w_op)
      OP_RTYPE: begin
        unique case (w_fn)
          FN_ADDU, FN_SUBU, FN_SLT: begin
            o_dest    = w_rd;
            o_tnew    = TNEW_1;
            o_tuse_rs = TUSE_1;
            o_tuse_rt = TUSE_1;
          end
          FN_JR: begin
            o_tuse_rs = TUSE_0;
          end
          FN_JALR: begin
            o_dest    = w_rd;
            o_tnew    = TNEW_0;
            o_tuse_rs = TUSE_0;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            o_tuse_rs      = TUSE_1;
            o_tuse_rt      = TUSE_1;
            o_is_md_start  = 1'b1;
            o_is_md_access = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            o_dest         = w_rd;
            o_tnew         = TNEW_1;
            o_is_md_access = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            o_tuse_rs      = TUSE_1;
            o_is_md_access = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_ADDIU: begin
        o_dest    = w_rt;
        o_tnew    = TNEW_1;
        o_tuse_rs = TUSE_1;
      end
      OP_LUI: begin
        o_dest = w_rt;
        o_tnew = TNEW_1;
      end
      OP_LW: begin
        o_dest    = w_rt;
        o_tnew    = TNEW_2;
        o_tuse_rs = TUSE_1;
      end
      OP_SW: begin
        o_tuse_rs = TUSE_1;
        o_tuse_rt = TUSE_2;
      end
      OP_BEQ, OP_BNE: begin
        o_tuse_rs = TUSE_0;
        o_tuse_rt = TUSE_0;
      end
      OP_JAL: begin
        o_dest = REG_RA;
        o_tnew = TNEW_0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/bubble controller: data hazards forwarding cannot cover, plus mult/div occupancy.
// Outputs are combinational from the IRs and the busy counter (zero latency).
// stall holds F/D and freezes PC; clr_DE bubbles D/E for the same cycle.
module hazard_stall_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  // 2**CNT_W must exceed max(MULT_CYCLES, DIV_CYCLES)
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  input  logic        RWE_E,
  input  logic        RWE_M,
  output logic        stall,
  output logic        clr_DE,
  output logic        pc_en,
  output logic        md_busy
);

  logic [4:0]       w_dest_e, w_dest_m;
  logic [1:0]       w_tnew_e, w_tnew_m_raw, w_tnew_m;
  logic [1:0]       w_tuse_rs_d, w_tuse_rt_d;
  logic             w_md_start_e, w_md_access_d;
  logic [4:0]       w_rs_d, w_rt_d;
  logic [4:0]       w_dest_e_g, w_dest_m_g;
  logic             w_data_stall;
  logic [CNT_W-1:0] r_md_cnt;

  // Outputs of the three decoder copies that this block does not need
  logic [4:0] w_unused_dest_d;
  logic [1:0] w_unused_tnew_d;
  logic       w_unused_md_start_d;
  logic [1:0] w_unused_tuse_rs_e, w_unused_tuse_rt_e;
  logic       w_unused_md_access_e;
  logic [1:0] w_unused_tuse_rs_m, w_unused_tuse_rt_m;
  logic       w_unused_md_start_m, w_unused_md_access_m;

  instr_decode u_dec_d (
    .i_ir           (IR_D),
    .o_dest         (w_unused_dest_d),
    .o_tnew         (w_unused_tnew_d),
    .o_tuse_rs      (w_tuse_rs_d),
    .o_tuse_rt      (w_tuse_rt_d),
    .o_is_md_start  (w_unused_md_start_d),
    .o_is_md_access (w_md_access_d)
  );

  instr_decode u_dec_e (
    .i_ir           (IR_E),
    .o_dest         (w_dest_e),
    .o_tnew         (w_tnew_e),
    .o_tuse_rs      (w_unused_tuse_rs_e),
    .o_tuse_rt      (w_unused_tuse_rt_e),
    .o_is_md_start  (w_md_start_e),
    .o_is_md_access (w_unused_md_access_e)
  );

  instr_decode u_dec_m (
    .i_ir           (IR_M),
    .o_dest         (w_dest_m),
    .o_tnew         (w_tnew_m_raw),
    .o_tuse_rs      (w_unused_tuse_rs_m),
    .o_tuse_rt      (w_unused_tuse_rt_m),
    .o_is_md_start  (w_unused_md_start_m),
    .o_is_md_access (w_unused_md_access_m)
  );

  assign w_rs_d     = IR_D[25:21];
  assign w_rt_d     = IR_D[20:16];
  assign w_tnew_m   = tnew_advance(w_tnew_m_raw);
  // A disabled write is presented as "writes $0", which never hazards
  assign w_dest_e_g = RWE_E ? w_dest_e : 5'd0;
  assign w_dest_m_g = RWE_M ? w_dest_m : 5'd0;

  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] de, input logic [1:0] te,
                                      input logic [4:0] dm, input logic [1:0] tm);
    return (src != 5'd0) &&
           (((src == de) && (tuse < te)) || ((src == dm) && (tuse < tm)));
  endfunction

  // Stall when a D-stage source is needed before the producer in E or M can forward it
  always_comb begin
    w_data_stall = src_hazard(w_rs_d, w_tuse_rs_d, w_dest_e_g, w_tnew_e, w_dest_m_g, w_tnew_m) |
                   src_hazard(w_rt_d, w_tuse_rt_d, w_dest_e_g, w_tnew_e, w_dest_m_g, w_tnew_m);
  end

  // Busy down-counter: a new mult/div in E reloads (load beats decrement), else count to 0.
  // funct bit 1 separates div/divu (1a/1b) from mult/multu (18/19).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (w_md_start_e && !IR_E[1]) begin
      r_md_cnt <= CNT_W'(MULT_CYCLES);
    end else if (w_md_start_e) begin
      r_md_cnt <= CNT_W'(DIV_CYCLES);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - CNT_W'(1);
    end
  end

  assign md_busy = (r_md_cnt != '0) | w_md_start_e;
  assign stall   = w_data_stall | (w_md_access_d & md_busy);
  assign clr_DE  = stall;
  assign pc_en   = ~stall;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Hazard detection and stall controller for the 5-stage MIPS pipeline.
- Decodes the instructions held in D, E and M and produces the control inputs the pipeline registers consume: hold F/D, bubble D/E, freeze PC.
- Tracks occupancy of the multi-cycle mult/div unit with an internal down-counter, so HI/LO accessors are held in D until the result is ready.
- Forwarding is handled elsewhere; this block only stalls when forwarding cannot satisfy a dependency.

Parameters:
- MULT_CYCLES, 5, extra busy cycles after a mult/multu leaves E
- DIV_CYCLES, 10, extra busy cycles after a div/divu leaves E
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears internal state
- IR_D  in  32  instruction in D stage
- IR_E  in  32  instruction in E stage
- IR_M  in  32  instruction in M stage
- RWE_E  in  1  register-write enable accompanying IR_E
- RWE_M  in  1  register-write enable accompanying IR_M
- stall  out  1  to F_D register stall input; 1 = hold
- clr_DE  out  1  to D_E register clr input; 1 = insert bubble
- pc_en  out  1  PC write enable; equals ~stall
- md_busy  out  1  mult/div unit occupied

Behaviour:
- Supported decode (all others are treated as no use/no write):
  - R-type (op 0) funct: addu 21, subu 23, slt 2a, jr 08, jalr 09, mult 18, multu 19, div 1a, divu 1b, mfhi 10, mthi 11, mflo 12, mtlo 13 (hex).
  - I/J opcodes: ori 0d, lui 0f, addiu 09, lw 23, sw 2b, beq 04, bne 05, j 02, jal 03.
- Destination register:
  - rd for addu/subu/slt/jalr/mfhi/mflo.
  - rt for ori/lui/addiu/lw.
  - 31 for jal.
  - Otherwise none.
- Tuse of the D-stage instruction:
  - rs: 0 for beq/bne/jr/jalr; 1 for ALU, lw/sw, mult/div, mthi/mtlo.
  - rt: 0 for beq/bne; 1 for addu/subu/slt/mult/div; 2 for sw.
- Tnew:
  - E stage: lw = 2; ALU/mfhi/mflo = 1; jal/jalr = 0.
  - M stage: lw = 1; others = 0.
- data_stall = 1 when all of the following hold for a source s of IR_D:
  - s != 0;
  - s == dest(X) for X in E (gated by RWE_E) or X in M (gated by RWE_M);
  - Tuse(s) < Tnew(X).
- md_op_D = IR_D is one of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- md counter md_cnt[CNT_W-1:0]:
  - Reset value 0.
  - At posedge, if IR_E is mult/multu, load MULT_CYCLES.
  - Else if IR_E is div/divu, load DIV_CYCLES.
  - Else if md_cnt != 0, decrement.
  - Else hold 0.
- md_busy = (md_cnt != 0) | IR_E is mult/multu/div/divu (combinational).
  - A mult in E keeps md_busy high for MULT_CYCLES+1 consecutive cycles.
  - A div in E keeps md_busy high for DIV_CYCLES+1 consecutive cycles.
- stall = data_stall | (md_op_D & md_busy); clr_DE = stall; pc_en = ~stall.
  - All combinational, same-cycle, zero latency.
- Simultaneous load and nonzero count cannot occur, because md ops are held in D while busy. If it does occur anyway, the load wins.
- reset asserted mid-count forces md_cnt = 0 immediately (asynchronous).
  - After reset, with all-zero IRs (sll $0 = nop): stall = 0, clr_DE = 0, pc_en = 1, md_busy = 0.
- Register 0 never creates a hazard. Unknown opcodes in E or M never write.

Decomposition:
- Shared package mips_defs holds:
  - opcode/funct localparams (OP_RTYPE, OP_LW, FN_ADDU, ...);
  - Tuse/Tnew constant encodings (2-bit);
  - the REG_RA = 31 constant.
- One sub-module, instr_decode, is instantiated three times (D, E, M). Its outputs are: dest register (5b), Tnew (2b), rs/rt Tuse (2b each, 3 = unused), is_md_start, is_md_access.
- The top level holds the counter and the stall equations.

Test Plan:
- lw $1,0($0) in E (RWE_E=1), addu $2,$1,$1 in D -> stall=1, clr_DE=1, pc_en=0. Next cycle, with lw in M and addu still in D -> stall=0.
- addu $3,$4,$5 in E, beq $3,$0 in D -> stall=1. Same addu in M, beq in D -> stall=0. Same pattern with dest $0 -> stall=0.
- sw $6,0($7) in D, lw $6 in M -> stall=0 (Tuse 2 ≥ Tnew 1). Same sw with lw $6 in E -> stall=0. sw $6 with lw $7 in E -> stall=1.
- mult $1,$2 in E, mflo $3 in D held -> md_busy=1 and stall=1 for exactly 6 cycles. mflo reaches E on the 7th edge. Same sequence with div -> 11 cycles.
- mult in E, then reset pulsed 2 cycles later with zero IRs -> md_cnt=0 and md_busy=0 asynchronously; stall=0 within the reset cycle.
- jal in E (RWE_E=1), jr $31 in D -> stall=0 (Tnew 0). jalr $5 in E writing $31, jr $31 in D -> stall=0.
